// File: rtl/jt51_shbuf_pkg.sv
// Shared types and width helper for the jt51_shbuf circular delay line.
package jt51_shbuf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } shbuf_state_t;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jt51_shbuf_ram.sv
// Storage for jt51_shbuf: one synchronous write port, two asynchronous reads.
module jt51_shbuf_ram #(
  parameter int unsigned width = 5,
  parameter int unsigned depth = 31,
  parameter int unsigned aw    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr_a,
  input  logic [aw-1:0]    raddr_b,
  output logic [width-1:0] rdata_a_c,
  output logic [width-1:0] rdata_b_c
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads return pre-write contents, so a same-cycle write never disturbs them.
  assign rdata_a_c = mem[raddr_a];
  assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/jt51_shbuf.sv
// Delay line of `stages` cen ticks on a circular buffer, with a random-access
// tap output and a self-clearing sweep of the storage after reset.
module jt51_shbuf
  import jt51_shbuf_pkg::*;
#(
  parameter int unsigned width  = 5,
  parameter int unsigned stages = 32,
  parameter logic        rstval = 1'b0,
  localparam int unsigned AW    = clog2(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [width-1:0] din,
  input  logic [AW-1:0]    tap,
  output logic [width-1:0] drop,
  output logic [width-1:0] tap_q,
  output logic             busy
);

  localparam int unsigned      DEPTH = stages - 1;
  localparam int unsigned      AW1   = AW + 1;
  localparam logic [AW-1:0]    LAST  = AW'(stages - 2);
  localparam logic [width-1:0] RWORD = {width{rstval}};

  shbuf_state_t     state, state_nxt;
  logic [AW-1:0]    wptr, wptr_nxt, wptr_inc;
  logic [AW-1:0]    tap_clamp, raddr;
  logic [AW1-1:0]   back_raw, back;
  logic             we, shift;
  logic [width-1:0] wdata, rd_w, rd_t, tap_sel;

  // Pointer arithmetic: wrap at DEPTH, tap address is (wptr - tap) mod DEPTH.
  always_comb begin
    wptr_inc  = (wptr == LAST) ? '0 : wptr + AW'(1);
    tap_clamp = (32'(tap) >= stages) ? AW'(DEPTH) : tap;
    back_raw  = AW1'(wptr) + AW1'(DEPTH) - AW1'(tap_clamp);
    back      = (back_raw >= AW1'(DEPTH)) ? back_raw - AW1'(DEPTH) : back_raw;
    raddr     = AW'(back);
    tap_sel   = (tap_clamp == '0) ? din : rd_t;
  end

  // Next state, pointer and memory write control.
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    we        = 1'b0;
    wdata     = din;
    shift     = 1'b0;
    unique case (state)
      CLEAR: begin
        we       = ~rst;
        wdata    = RWORD;
        wptr_nxt = wptr_inc;
        if (wptr == LAST) state_nxt = RUN;
      end
      RUN: begin
        if (cen) begin
          shift    = ~rst;
          we       = ~rst;
          wptr_nxt = wptr_inc;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      wptr  <= '0;
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b1;
      drop  <= RWORD;
      tap_q <= RWORD;
    end else begin
      busy <= (state_nxt == CLEAR);
      if (shift) begin
        drop  <= rd_w;
        tap_q <= tap_sel;
      end
    end
  end

  jt51_shbuf_ram #(
    .width (width),
    .depth (DEPTH),
    .aw    (AW)
  ) u_ram (
    .clk       (clk),
    .we        (we),
    .waddr     (wptr),
    .wdata     (wdata),
    .raddr_a   (wptr),
    .raddr_b   (raddr),
    .rdata_a_c (rd_w),
    .rdata_b_c (rd_t)
  );

endmodule

// File: tb/tb_jt51_shbuf.sv
// Randomised bench for jt51_shbuf at stages 32, 20 (tap clamping) and 2.
module tb_jt51_shbuf;

  logic       clk;
  logic       rst, cen;
  logic [4:0] din;
  logic [4:0] tap32, tap20;
  logic [0:0] tap2;
  logic [4:0] drop32, drop20, drop2, tq32, tq20, tq2;
  logic       busy32, busy20, busy2;

  int         tapv [3];
  logic [4:0] drop_a [3];
  logic [4:0] tq_a [3];
  logic       busy_a [3];

  assign tap32 = 5'(tapv[0]);
  assign tap20 = 5'(tapv[1]);
  assign tap2  = 1'(tapv[2]);
  assign drop_a[0] = drop32; assign drop_a[1] = drop20; assign drop_a[2] = drop2;
  assign tq_a[0]   = tq32;   assign tq_a[1]   = tq20;   assign tq_a[2]   = tq2;
  assign busy_a[0] = busy32; assign busy_a[1] = busy20; assign busy_a[2] = busy2;

  jt51_shbuf #(.width(5), .stages(32), .rstval(1'b1)) dut32 (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .tap(tap32),
    .drop(drop32), .tap_q(tq32), .busy(busy32));
  jt51_shbuf #(.width(5), .stages(20), .rstval(1'b0)) dut20 (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .tap(tap20),
    .drop(drop20), .tap_q(tq20), .busy(busy20));
  jt51_shbuf #(.width(5), .stages(2), .rstval(1'b1)) dut2 (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .tap(tap2),
    .drop(drop2), .tap_q(tq2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance history of words accepted on honoured ticks.
  int         S  [3] = '{32, 20, 2};
  logic       RV [3] = '{1'b1, 1'b0, 1'b1};
  logic [4:0] hv [3][1024];
  int         n [3];
  int         clr [3];
  int         ltap [3];
  logic       bm [3];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  function automatic logic [4:0] rword(input int d);
    return {5{RV[d]}};
  endfunction

  function automatic logic [4:0] exp_drop(input int d);
    int idx;
    idx = n[d] - S[d];
    return (idx >= 0) ? hv[d][idx] : rword(d);
  endfunction

  function automatic logic [4:0] exp_tap(input int d);
    int t, idx;
    t   = (ltap[d] > S[d] - 1) ? S[d] - 1 : ltap[d];
    idx = n[d] - 1 - t;
    return (idx >= 0) ? hv[d][idx] : rword(d);
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic [4:0] dv);
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        n[d] = 0; clr[d] = S[d] - 1; bm[d] = 1'b1;
      end else if (clr[d] > 0) begin
        clr[d]--; bm[d] = (clr[d] > 0);
      end else if (c) begin
        if (n[d] < 1024) hv[d][n[d]] = dv;
        n[d]++;
        ltap[d] = tapv[d];
      end
    end
  endtask

  // Drive inputs on the falling edge, clock once, advance the model, settle.
  task automatic step(input logic r, input logic c, input logic [4:0] dv);
    @(negedge clk);
    rst = r; cen = c; din = dv;
    @(posedge clk);
    model_edge(r, c, dv);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 5'(($urandom)));
    step(1'b1, 1'b0, 5'(($urandom)));
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_a[d] !== 1'b1) begin
        errors++; $display("FAIL reset_busy dut%0d: got %b want 1", d, busy_a[d]);
      end
      checks++;
      if (drop_a[d] !== rword(d)) begin
        errors++; $display("FAIL reset_drop dut%0d: got %h want %h", d, drop_a[d], rword(d));
      end
      checks++;
      if (tq_a[d] !== rword(d)) begin
        errors++; $display("FAIL reset_tap_q dut%0d: got %h want %h", d, tq_a[d], rword(d));
      end
    end
  endtask

  // Release reset and measure how many edges each instance stays busy.
  task automatic test_sweep(input string tag);
    int fell [3];
    for (int d = 0; d < 3; d++) fell[d] = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 5'(($urandom)));
      for (int d = 0; d < 3; d++) begin
        if (fell[d] == 0 && busy_a[d] === 1'b0) fell[d] = i;
        checks++;
        if (busy_a[d] !== bm[d]) begin
          errors++; $display("FAIL %s_busy dut%0d cyc%0d: got %b want %b", tag, d, cyc, busy_a[d], bm[d]);
        end
        checks++;
        if (drop_a[d] !== exp_drop(d)) begin
          errors++; $display("FAIL %s_drop dut%0d cyc%0d: got %h want %h", tag, d, cyc, drop_a[d], exp_drop(d));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (fell[d] != S[d] - 1) begin
        errors++; $display("FAIL %s_len dut%0d: got %0d want %0d edges", tag, d, fell[d], S[d] - 1);
      end
    end
  endtask

  // Run a stretch of cycles and compare every output against the model.
  task automatic run_and_check(input string tag, input int cycles, input int cen_mode,
                               input bit count_din, input bit rand_tap);
    logic c;
    logic [4:0] dv;
    for (int i = 0; i < cycles; i++) begin
      case (cen_mode)
        0: c = 1'b1;
        1: c = (i % 3 == 2);
        default: c = 1'($urandom);
      endcase
      dv = count_din ? 5'(i) : 5'($urandom);
      if (rand_tap) begin
        tapv[0] = int'($urandom_range(0, 31));
        tapv[1] = int'($urandom_range(0, 31));
        tapv[2] = int'($urandom_range(0, 1));
      end
      step(1'b0, c, dv);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (drop_a[d] !== exp_drop(d)) begin
          errors++; $display("FAIL %s_drop dut%0d cyc%0d: got %h want %h", tag, d, cyc, drop_a[d], exp_drop(d));
        end
        checks++;
        if (tq_a[d] !== exp_tap(d)) begin
          errors++; $display("FAIL %s_tap_q dut%0d cyc%0d: got %h want %h", tag, d, cyc, tq_a[d], exp_tap(d));
        end
        checks++;
        if (busy_a[d] !== 1'b0) begin
          errors++; $display("FAIL %s_busy dut%0d cyc%0d: got %b want 0", tag, d, cyc, busy_a[d]);
        end
      end
    end
  endtask

  task automatic test_pure_delay();
    tapv[0] = 31; tapv[1] = 19; tapv[2] = 1;
    run_and_check("pure", 80, 0, 1'b1, 1'b0);
  endtask

  task automatic test_sparse_cen();
    tapv[0] = 12; tapv[1] = 5; tapv[2] = 0;
    run_and_check("sparse", 90, 1, 1'b0, 1'b0);
  endtask

  task automatic test_tap_sweep();
    int t32 [5] = '{0, 1, 17, 31, 31};
    int t20 [5] = '{0, 1, 17, 25, 31};
    for (int k = 0; k < 5; k++) begin
      tapv[0] = t32[k]; tapv[1] = t20[k]; tapv[2] = k % 2;
      run_and_check("tap", 10, 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    run_and_check("rand", 300, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 5'(($urandom)));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 5'(($urandom)));
      checks++;
      if (busy32 !== 1'b1) begin
        errors++; $display("FAIL mid_busy cyc%0d: got %b want 1", cyc, busy32);
      end
    end
    step(1'b1, 1'b0, 5'(($urandom)));
    test_sweep("resweep");
    tapv[0] = 31; tapv[1] = 19; tapv[2] = 1;
    run_and_check("post", 40, 2, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; din = '0;
    for (int d = 0; d < 3; d++) begin
      tapv[d] = 0; n[d] = 0; clr[d] = 0; ltap[d] = 0; bm[d] = 1'b1;
    end
    test_reset();
    test_sweep("sweep");
    test_pure_delay();
    test_sparse_cen();
    test_tap_sweep();
    test_random();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
